rgb_led_arbiter: RTL and testbench

- Shares the single on-board RGB LED between N_REQ requesters, e.g. colour-cycle sequencer, error alert and heartbeat.
- Each requester asks for a 3-bit colour for a dwell time measured in prescaled ticks.
- Grants are round-robin and hold for the full dwell, then the LED goes dark.
- Sits between the LED pattern generators and the top-level red/green/blue pins.

---
 rtl/rgb_led_arbiter.sv | 119 +++++++++++
 tb/tb_rgb_led_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: round-robin owner of the shared board RGB LED.
// Define LED_ARB_GAP_EN to add a dark GAP state after every grant.
module rgb_led_arbiter #(
  parameter int TICK_DIV = 12000,
  parameter int N_REQ    = 3,
  parameter int DWELL_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [3*N_REQ-1:0]         color,
  input  logic [DWELL_W*N_REQ-1:0]   dwell,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic                       red,
  output logic                       green,
  output logic                       blue
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = $clog2(N_REQ);

`ifdef LED_ARB_GAP_EN
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  localparam state_t END_ST = GAP;
`else
  typedef enum logic {IDLE, HOLD} state_t;
  localparam state_t END_ST = IDLE;
`endif

  state_t             state;
  logic [PW-1:0]      presc;
  logic               tick;
  logic [DWELL_W-1:0] hold_cnt;
  logic [LW-1:0]      last;
  logic [LW-1:0]      own;
  logic [LW-1:0]      win;
  logic               hit;
  logic               fin;
  logic [2:0]         col_sel;
  logic [DWELL_W-1:0] dw_sel;

  assign tick = (presc == PW'(TICK_DIV - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Lowest k wins: scan from far to near so the nearest set bit sticks.
  always_comb begin
    win = last;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_REQ]) begin
        win = LW'((int'(last) + k) % N_REQ);
      end
    end
  end

  assign hit     = |req;
  assign col_sel = color[3*int'(win) +: 3];
  assign dw_sel  = dwell[DWELL_W*int'(win) +: DWELL_W];
  assign fin     = !req[own] || (tick && hold_cnt == DWELL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      grant              <= '0;
      done               <= '0;
      {red, green, blue} <= 3'b000;
      hold_cnt           <= '0;
      last               <= LW'(N_REQ - 1);
      own                <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            own                <= win;
            grant              <= N_REQ'(1) << win;
            {red, green, blue} <= col_sel;
            hold_cnt           <= (dw_sel == '0) ? DWELL_W'(1) : dw_sel;
            state              <= HOLD;
          end
        end
        HOLD: begin
          if (fin) begin
            grant              <= '0;
            {red, green, blue} <= 3'b000;
            last               <= own;
            state              <= END_ST;
            // A dropped request is an abort and never reports done.
            if (req[own]) begin
              done <= N_REQ'(1) << own;
            end
          end else if (tick) begin
            hold_cnt <= hold_cnt - DWELL_W'(1);
          end
        end
`ifdef LED_ARB_GAP_EN
        GAP: begin
          if (tick) begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: scoreboard bench for rgb_led_arbiter.
// Expected grants are queued at stimulus time and matched by a monitor.
module tb_rgb_led_arbiter;

  localparam int TD = 4;
  localparam int NR = 3;
  localparam int DW = 8;
`ifdef LED_ARB_GAP_EN
  localparam int GAP_LO = 2;
  localparam int GAP_HI = TD + 1;
`else
  localparam int GAP_LO = 1;
  localparam int GAP_HI = 1;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req   = '0;
  logic [3*NR-1:0]  color = '0;
  logic [DW*NR-1:0] dwell = '0;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    done;
  logic             busy;
  logic             red;
  logic             green;
  logic             blue;
  logic [2:0]       rgb;

  typedef struct {
    logic [2:0] g;
    logic [2:0] c;
    int         dw;
    logic       ab;
    logic       gc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            s_cyc = 0;
  int            e_cyc = 0;
  int            held;
  int            gap;
  logic [NR-1:0] prev_g = '0;

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  rgb_led_arbiter #(
    .TICK_DIV(TD),
    .N_REQ   (NR),
    .DWELL_W (DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .color(color),
    .dwell(dwell),
    .grant(grant),
    .done (done),
    .busy (busy),
    .red  (red),
    .green(green),
    .blue (blue)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
  endtask

  function automatic exp_t mk(input logic [2:0] g, input logic [2:0] c,
                              input int dw, input logic ab, input logic gc);
    exp_t e;
    e.g  = g;
    e.c  = c;
    e.dw = dw;
    e.ab = ab;
    e.gc = gc;
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_g = '0;
    end else begin
      chk("onehot", 32'($onehot0(grant)), 32'd1);
      if (grant != '0 && prev_g == '0) begin
        if (exp_q.size() == 0) begin
          chk("unexp_grant", 32'(grant), 32'd0);
          cur = mk(grant, rgb, TD, 1'b1, 1'b0);
        end else begin
          cur = exp_q.pop_front();
        end
        chk("grant", 32'(grant), 32'(cur.g));
        if (cur.gc) begin
          gap = cyc - e_cyc;
          chk("gap", 32'(gap >= GAP_LO && gap <= GAP_HI), 32'd1);
        end
        s_cyc = cyc;
      end
      if (grant == '0 && prev_g != '0) begin
        e_cyc = cyc;
        held  = cyc - s_cyc;
        if (cur.ab) begin
          chk("abort_done", 32'(done), 32'd0);
        end else begin
          chk("done", 32'(done), 32'(prev_g));
          chk("hold_len", 32'(held >= (cur.dw - 1) * TD + 1 &&
                              held <= cur.dw * TD), 32'd1);
        end
      end else begin
        chk("done_quiet", 32'(done), 32'd0);
      end
      if (grant != '0) begin
        chk("rgb_hold", 32'(rgb), 32'(cur.c));
        chk("busy", 32'(busy), 32'd1);
      end else begin
        chk("rgb_dark", 32'(rgb), 32'd0);
      end
      prev_g = grant;
    end
  end

  task automatic wait_grant(input string tag);
    int n = 0;
    while (grant == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(grant != '0), 32'd1);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    wait_grant(tag);
    while (grant != '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(grant == '0), 32'd1);
  endtask

  task automatic do_reset(input logic [NR-1:0] r);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    exp_q.delete();
    req = r;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset while a grant is live and all requesters are asking
    color = {3'b101, 3'b010, 3'b100};
    dwell = {8'd2, 8'd2, 8'd2};
    @(negedge clk);
    exp_q.push_back(mk(3'b001, 3'b100, 2, 1'b0, 1'b0));
    req = 3'b111;
    wait_grant("t1_grant");
    do_reset(3'b000);
    repeat (20) @(negedge clk);
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // single request, latency and dwell
    color = {3'b000, 3'b000, 3'b100};
    dwell = {8'd0, 8'd0, 8'd3};
    exp_q.push_back(mk(3'b001, 3'b100, 3, 1'b0, 1'b0));
    req = 3'b001;
    @(negedge clk);
    chk("t2_lat_grant", 32'(grant), 32'd1);
    chk("t2_lat_red", 32'(red), 32'd1);
    wait_end("t2_end");
    req = 3'b000;

    // round-robin storm from a fresh pointer
    @(negedge clk);
    do_reset(3'b000);
    color = {3'b001, 3'b010, 3'b100};
    dwell = {8'd1, 8'd1, 8'd1};
    exp_q.push_back(mk(3'b001, 3'b100, 1, 1'b0, 1'b0));
    exp_q.push_back(mk(3'b010, 3'b010, 1, 1'b0, 1'b1));
    exp_q.push_back(mk(3'b100, 3'b001, 1, 1'b0, 1'b1));
    exp_q.push_back(mk(3'b001, 3'b100, 1, 1'b0, 1'b1));
    req = 3'b111;
    repeat (4) wait_end("t3_end");
    req = 3'b000;

    // abort, then requester 2 beats requester 1
    repeat (8) @(negedge clk);
    color = {3'b101, 3'b011, 3'b000};
    dwell = {8'd2, 8'd5, 8'd0};
    exp_q.push_back(mk(3'b010, 3'b011, 5, 1'b1, 1'b0));
    req = 3'b010;
    wait_grant("t4_grant");
    repeat (6) @(negedge clk);
    req = 3'b000;
    @(negedge clk);
    chk("t4_drop_grant", 32'(grant), 32'd0);
    chk("t4_drop_rgb", 32'(rgb), 32'd0);
    exp_q.push_back(mk(3'b100, 3'b101, 2, 1'b0, 1'b0));
    req = 3'b110;
    wait_end("t4_end");
    req = 3'b000;

    // zero dwell behaves as one tick
    repeat (8) @(negedge clk);
    color = {3'b001, 3'b000, 3'b000};
    dwell = '0;
    exp_q.push_back(mk(3'b100, 3'b001, 1, 1'b0, 1'b0));
    req = 3'b100;
    wait_end("t5_end");
    req = 3'b000;

    // reset in the middle of a hold
    repeat (8) @(negedge clk);
    color = {3'b000, 3'b000, 3'b110};
    dwell = {8'd0, 8'd0, 8'd3};
    exp_q.push_back(mk(3'b001, 3'b110, 3, 1'b0, 1'b0));
    req = 3'b001;
    wait_grant("t6_grant");
    repeat (3) @(negedge clk);
    do_reset(3'b011);
    exp_q.push_back(mk(3'b001, 3'b110, 3, 1'b0, 1'b0));
    wait_end("t6_end");
    req = 3'b000;

    repeat (10) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
